// File: rtl/capture_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | capture_scheduler: per-frame commit sequencing of camera pixels into the   |
// | frame buffer. Optional CAPTURE_STATS_EN adds per-frame pixel statistics.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module capture_scheduler #(
  parameter int ADDR_W  = 17,
  parameter int MAX_PIX = 76800,
  parameter int CNT_W   = 8
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              pix_we,
  input  logic [1:0]        mode,
  input  logic              snap,
  input  logic [3:0]        skip,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              frame_done,
  output logic              busy,
  output logic              overflow,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [ADDR_W-1:0] last_pix_cnt
);

  localparam logic [ADDR_W:0] c_max_pix   = (ADDR_W+1)'(MAX_PIX);
  localparam logic [1:0]      c_mode_cont = 2'b00;
  localparam logic [1:0]      c_mode_snap = 2'b01;
  localparam logic [1:0]      c_mode_frz  = 2'b10;
  localparam logic [1:0]      c_mode_dec  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DROP    = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_vs_q;
  logic              r_armed;
  logic [3:0]        r_skip_cnt;
  // One extra bit so the pixel count can reach MAX_PIX even when it fills the address space
  logic [ADDR_W:0]   r_pix_cnt;
  logic              w_frame_start;
  logic              w_frame_end;
  logic              w_commit;

  assign w_frame_start = r_vs_q & ~vsync;
  assign w_frame_end   = ~r_vs_q & vsync;

  // A snap coinciding with frame start counts for the frame that is starting
  always_comb begin
    w_commit = 1'b0;
    case (mode)
      c_mode_cont: w_commit = 1'b1;
      c_mode_snap: w_commit = r_armed | snap;
      c_mode_frz:  w_commit = 1'b0;
      c_mode_dec:  w_commit = (r_skip_cnt == 4'd0);
      default:     w_commit = 1'b0;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_vs_q     <= 1'b0;
      r_armed    <= 1'b0;
      r_skip_cnt <= 4'd0;
      r_pix_cnt  <= '0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      r_vs_q     <= vsync;
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      if (snap) begin
        r_armed <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_frame_start) begin
            r_pix_cnt <= '0;
            fb_addr   <= '0;
            if (mode == c_mode_snap) begin
              r_armed <= 1'b0;
            end
            if (mode == c_mode_dec) begin
              r_skip_cnt <= (r_skip_cnt == 4'd0) ? skip : r_skip_cnt - 4'd1;
            end
            if (w_commit) begin
              r_state <= S_CAPTURE;
              busy    <= 1'b1;
            end else begin
              r_state <= S_DROP;
            end
          end
        end
        S_CAPTURE: begin
          if (w_frame_end) begin
            r_state    <= S_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + CNT_W'(1);
          end else if (pix_we && !vsync) begin
            if (r_pix_cnt < c_max_pix) begin
              fb_we     <= 1'b1;
              fb_addr   <= r_pix_cnt[ADDR_W-1:0];
              r_pix_cnt <= r_pix_cnt + (ADDR_W+1)'(1);
            end else begin
              overflow <= 1'b1;
            end
          end
        end
        S_DROP: begin
          if (w_frame_end) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CAPTURE_STATS_EN
  // Counts every accepted pixel, including those dropped for overflow
  logic [ADDR_W-1:0] r_stat_cnt;

  always_ff @(posedge pclk) begin
    if (!reset) begin
      r_stat_cnt   <= '0;
      last_pix_cnt <= '0;
    end else if (r_state == S_IDLE && w_frame_start) begin
      r_stat_cnt <= '0;
    end else if (r_state == S_CAPTURE) begin
      if (w_frame_end) begin
        last_pix_cnt <= r_stat_cnt;
      end else if (pix_we && !vsync && r_stat_cnt != '1) begin
        r_stat_cnt <= r_stat_cnt + ADDR_W'(1);
      end
    end
  end
`else
  assign last_pix_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_capture_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_capture_scheduler: randomized scoreboard bench for capture_scheduler.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_capture_scheduler;

  localparam int ADDR_W  = 17;
  localparam int MAX_PIX = 100;
  localparam int CNT_W   = 8;

  logic              pclk = 1'b0;
  logic              reset = 1'b0;
  logic              vsync = 1'b1;
  logic              pix_we = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic              snap = 1'b0;
  logic [3:0]        skip = 4'd0;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic              frame_done;
  logic              busy;
  logic              overflow;
  logic [CNT_W-1:0]  frame_cnt;
  logic [ADDR_W-1:0] last_pix_cnt;

  capture_scheduler #(.ADDR_W(ADDR_W), .MAX_PIX(MAX_PIX), .CNT_W(CNT_W)) dut (
    .pclk(pclk), .reset(reset), .vsync(vsync), .pix_we(pix_we), .mode(mode),
    .snap(snap), .skip(skip), .fb_we(fb_we), .fb_addr(fb_addr),
    .frame_done(frame_done), .busy(busy), .overflow(overflow),
    .frame_cnt(frame_cnt), .last_pix_cnt(last_pix_cnt)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int cnt;
    int lp;
  } done_t;

  int    exp_addr[$];
  done_t exp_done[$];
  int    n_checks = 0;
  int    n_fails  = 0;

  // Reference model state
  bit mdl_armed = 0;
  int mdl_skip  = 0;
  int mdl_cnt   = 0;
  bit mdl_ovf   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  function automatic bit model_start(input bit snap_now);
    bit c;
    if (snap_now) mdl_armed = 1;
    c = 0;
    case (mode)
      2'b00: c = 1;
      2'b01: begin c = mdl_armed; mdl_armed = 0; end
      2'b10: c = 0;
      default: begin
        if (mdl_skip == 0) begin c = 1; mdl_skip = int'(skip); end
        else mdl_skip = mdl_skip - 1;
      end
    endcase
    return c;
  endfunction

  task automatic model_reset();
    mdl_armed = 0;
    mdl_skip  = 0;
    mdl_cnt   = 0;
    mdl_ovf   = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_fb_we"}, 32'(fb_we), 0);
    chk({tag, "_fb_addr"}, 32'(fb_addr), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
    chk({tag, "_last_pix_cnt"}, 32'(last_pix_cnt), 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or frame completion
  always @(negedge pclk) begin
    if (fb_we) begin
      if (exp_addr.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL fb_we_unexpected: got write at addr %0d, required no write", fb_addr);
      end else begin
        chk("fb_addr", 32'(fb_addr), 32'(exp_addr.pop_front()));
      end
    end
    if (frame_done) begin
      if (exp_done.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL frame_done_unexpected: got pulse, required none");
      end else begin
        done_t d;
        d = exp_done.pop_front();
        chk("done_frame_cnt", 32'(frame_cnt), 32'(d.cnt));
        chk("done_last_pix_cnt", 32'(last_pix_cnt), 32'(d.lp));
      end
    end
  end

  task automatic pulse_snap();
    snap = 1;
    mdl_armed = 1;
    step();
    snap = 0;
  endtask

  task automatic run_frame(input int npix, input bit snap_start, input int snap_at,
                           input int mode_at, input logic [1:0] new_mode, input int rst_at);
    bit commit;
    int lp;
    vsync = 0;
    snap  = snap_start;
    commit = model_start(snap_start);
    step();
    snap = 0;
    @(negedge pclk);
    chk("busy_in_frame", 32'(busy), 32'(commit));
    for (int i = 0; i < npix; i++) begin
      if (i == rst_at) begin
        pix_we = 0;
        reset  = 0;
        step();
        reset = 1;
        model_reset();
        commit = 0;
        @(negedge pclk);
        check_zero("midreset");
      end
      if (i == mode_at) mode = new_mode;
      if (i == snap_at) begin snap = 1; mdl_armed = 1; end
      if ($urandom_range(3) == 0) begin
        pix_we = 0;
        step();
        snap = 0;
      end
      pix_we = 1;
      if (commit) begin
        if (i < MAX_PIX) exp_addr.push_back(i);
        else mdl_ovf = 1;
      end
      step();
      snap = 0;
    end
    pix_we = 0;
    vsync  = 1;
    if (commit) begin
      mdl_cnt = (mdl_cnt + 1) % (1 << CNT_W);
`ifdef CAPTURE_STATS_EN
      lp = (npix > (1 << ADDR_W) - 1) ? (1 << ADDR_W) - 1 : npix;
`else
      lp = 0;
`endif
      exp_done.push_back('{cnt: mdl_cnt, lp: lp});
    end
    step();
    // Blanking with junk strobes that must be ignored
    repeat (2 + $urandom_range(3)) begin
      pix_we = 1'($urandom_range(1));
      step();
    end
    pix_we = 0;
    @(negedge pclk);
    chk("busy_blank", 32'(busy), 0);
    chk("overflow", 32'(overflow), 32'(mdl_ovf));
    chk("frame_cnt", 32'(frame_cnt), 32'(mdl_cnt));
  endtask

  initial begin
    reset = 0;
    repeat (3) step();
    @(negedge pclk);
    check_zero("reset");
    reset = 1;
    step();
    step();

    // Continuous: two full frames
    mode = 2'b00;
    repeat (2) run_frame(MAX_PIX, 0, -1, -1, 2'b00, -1);

    // Single-shot: nothing until armed, snap between frames, then snap at frame start
    mode = 2'b01;
    repeat (2) run_frame(40, 0, -1, -1, 2'b00, -1);
    pulse_snap();
    repeat (2) run_frame(40, 0, -1, -1, 2'b00, -1);
    run_frame(30, 1, -1, -1, 2'b00, -1);
    run_frame(30, 0, -1, -1, 2'b00, -1);

    // Decimate skip=2: commit 1, drop 2; then skip=0 commits every frame
    mode = 2'b11;
    skip = 4'd2;
    repeat (7) run_frame(20, 0, -1, -1, 2'b00, -1);
    skip = 4'd0;
    repeat (2) run_frame(20, 0, -1, -1, 2'b00, -1);

    // Overflow: two pixels past buffer depth, sticky into next frame
    mode = 2'b00;
    run_frame(MAX_PIX + 2, 0, -1, -1, 2'b00, -1);
    run_frame(10, 0, -1, -1, 2'b00, -1);

    // Reset mid-frame, then a fresh full frame
    run_frame(60, 0, -1, -1, 2'b00, 30);
    run_frame(MAX_PIX, 0, -1, -1, 2'b00, -1);

    // Switch to freeze mid-frame: current frame completes, later frames dropped
    run_frame(50, 0, -1, 25, 2'b10, -1);
    repeat (2) run_frame(30, 0, -1, -1, 2'b00, -1);

    // Randomized frames
    repeat (16) begin
      mode = 2'($urandom_range(3));
      skip = 4'($urandom_range(3));
      if ($urandom_range(3) == 0) pulse_snap();
      run_frame($urandom_range(MAX_PIX + 5), ($urandom_range(3) == 0),
                ($urandom_range(2) == 0) ? int'($urandom_range(20)) : -1, -1, 2'b00, -1);
    end

    repeat (4) step();
    chk("addr_queue_empty", 32'(exp_addr.size()), 0);
    chk("done_queue_empty", 32'(exp_done.size()), 0);
    chk("final_frame_cnt", 32'(frame_cnt), 32'(mdl_cnt));
    chk("final_overflow", 32'(overflow), 32'(mdl_ovf));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
